// File: rtl/ioconfig_loader.sv
// Serial configuration loader: hunts for a sync header, shifts in per-IO TSMUX/DORREG
// fields with even parity, and atomically commits them to the IO configuration outputs.

module ioconfig_slice (
    input  logic       IOCLK,
    input  logic       RST,
    input  logic       load,
    input  logic [2:0] fld,
    output logic [1:0] tsmux,
    output logic       dorreg
);
    always_ff @(posedge IOCLK or posedge RST) begin
        if (RST) begin
            tsmux  <= 2'b00;
            dorreg <= 1'b0;
        end else if (load) begin
            tsmux  <= fld[2:1];
            dorreg <= fld[0];
        end
    end
endmodule

module ioconfig_loader #(
    parameter int          NUM_IO = 8,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic                  IOCLK,
    input  logic                  RST,
    input  logic                  CFG_DIN,
    input  logic                  CFG_VALID,
    output logic                  CFG_READY,
    input  logic                  CFG_ABORT,
    output logic [2*NUM_IO-1:0]   TSMUX_OUT,
    output logic [NUM_IO-1:0]     DORREG_OUT,
    output logic                  CFG_DONE,
    output logic                  CFG_ERR
);
    localparam int P  = 3 * NUM_IO;
    localparam int CW = $clog2(P + 1);

    typedef enum logic [1:0] {HUNT, LOAD, PARITY, COMMIT} state_t;

    state_t          state, state_nxt;
    logic [7:0]      window;
    logic [7:0]      window_shift;
    logic [P-1:0]    shadow;
    logic [CW-1:0]   cnt;
    logic            par;
    logic            xfer;
    logic            sync_hit;
    logic            last_bit;
    logic            commit_ok;
    logic            commit_bad;

    assign CFG_READY    = (state != COMMIT);
    assign xfer         = CFG_VALID && CFG_READY;
    assign window_shift = {window[6:0], CFG_DIN};
    assign sync_hit     = (window_shift == SYNC);
    assign last_bit     = (cnt == CW'(P - 1));
    // An abort landing in the commit cycle cancels the commit entirely.
    assign commit_ok    = (state == COMMIT) && !CFG_ABORT && !par;
    assign commit_bad   = (state == COMMIT) && !CFG_ABORT &&  par;

    always_ff @(posedge IOCLK or posedge RST) begin
        if (RST) state <= HUNT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HUNT:    if (xfer && sync_hit) state_nxt = LOAD;
            LOAD:    if (xfer && last_bit) state_nxt = PARITY;
            PARITY:  if (xfer)             state_nxt = COMMIT;
            COMMIT:                        state_nxt = HUNT;
            default:                       state_nxt = HUNT;
        endcase
        if (CFG_ABORT) state_nxt = HUNT;
    end

    always_ff @(posedge IOCLK or posedge RST) begin
        if (RST) begin
            window   <= '0;
            shadow   <= '0;
            cnt      <= '0;
            par      <= 1'b0;
            CFG_DONE <= 1'b0;
            CFG_ERR  <= 1'b0;
        end else begin
            CFG_DONE <= commit_ok;
            CFG_ERR  <= commit_bad;
            if (CFG_ABORT) begin
                window <= '0;
                cnt    <= '0;
                par    <= 1'b0;
            end else begin
                case (state)
                    HUNT: if (xfer) begin
                        if (sync_hit) begin
                            window <= '0;
                            cnt    <= '0;
                            par    <= 1'b0;
                        end else begin
                            window <= window_shift;
                        end
                    end
                    LOAD: if (xfer) begin
                        shadow <= {shadow[P-2:0], CFG_DIN};
                        par    <= par ^ CFG_DIN;
                        cnt    <= cnt + 1'b1;
                    end
                    PARITY: if (xfer) par <= par ^ CFG_DIN;
                    // Leaving COMMIT re-enters HUNT with a clean window.
                    COMMIT: begin
                        window <= '0;
                        cnt    <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar i = 0; i < NUM_IO; i++) begin : g_io
        ioconfig_slice u_slice (
            .IOCLK  (IOCLK),
            .RST    (RST),
            .load   (commit_ok),
            .fld    (shadow[3*i+2:3*i]),
            .tsmux  (TSMUX_OUT[2*i+1:2*i]),
            .dorreg (DORREG_OUT[i])
        );
    end
endmodule

// File: tb/tb_ioconfig_loader.sv
// Directed scoreboard bench for ioconfig_loader with NUM_IO=2: stimulus pushes expected
// commit/error events, a negedge monitor pops and compares them when a pulse appears.

module tb_ioconfig_loader;
    logic       IOCLK = 1'b0;
    logic       RST;
    logic       CFG_DIN;
    logic       CFG_VALID;
    logic       CFG_READY;
    logic       CFG_ABORT;
    logic [3:0] TSMUX_OUT;
    logic [1:0] DORREG_OUT;
    logic       CFG_DONE;
    logic       CFG_ERR;

    ioconfig_loader #(.NUM_IO(2), .SYNC(8'hA5)) dut (
        .IOCLK      (IOCLK),
        .RST        (RST),
        .CFG_DIN    (CFG_DIN),
        .CFG_VALID  (CFG_VALID),
        .CFG_READY  (CFG_READY),
        .CFG_ABORT  (CFG_ABORT),
        .TSMUX_OUT  (TSMUX_OUT),
        .DORREG_OUT (DORREG_OUT),
        .CFG_DONE   (CFG_DONE),
        .CFG_ERR    (CFG_ERR)
    );

    always #5 IOCLK = ~IOCLK;

    typedef struct {
        bit         err;
        logic [3:0] ts;
        logic [1:0] dr;
        int         edge_n;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge IOCLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every DONE/ERR pulse must match the oldest queued expectation.
    always @(negedge IOCLK) begin
        if (!RST && (CFG_DONE || CFG_ERR)) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: got done=%0b err=%0b expected none (cycle %0d)",
                         CFG_DONE, CFG_ERR, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("pulse_kind", {30'd0, CFG_DONE, CFG_ERR}, e.err ? 32'd1 : 32'd2);
                chk("tsmux", {28'd0, TSMUX_OUT}, {28'd0, e.ts});
                chk("dorreg", {30'd0, DORREG_OUT}, {30'd0, e.dr});
                chk("pulse_edge", cyc, e.edge_n);
            end
        end
    end

    // All tasks start and end just after a falling edge.
    task automatic send_bit(input bit b);
        int tries;
        bit acc;
        tries = 0;
        CFG_DIN   = b;
        CFG_VALID = 1'b1;
        do begin
            acc = CFG_READY;
            @(posedge IOCLK);
            @(negedge IOCLK);
            tries++;
        end while (!acc && tries < 16);
        CFG_VALID = 1'b0;
        if (!acc) chk("send_bit_timeout", 32'd0, 32'd1);
    endtask

    task automatic gap(input bit rnd);
        int n;
        n = rnd ? int'($urandom_range(0, 3)) : 0;
        repeat (n) begin
            CFG_DIN = 1'($urandom);
            @(posedge IOCLK);
            @(negedge IOCLK);
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input bit rnd);
        for (int i = 7; i >= 0; i--) begin
            gap(rnd);
            send_bit(v[i]);
        end
    endtask

    task automatic send_frame(input logic [5:0] pl, input bit p, input bit exp_err,
                              input logic [3:0] ets, input logic [1:0] edr, input bit rnd);
        exp_t e;
        send_byte(8'hA5, rnd);
        for (int i = 5; i >= 0; i--) begin
            gap(rnd);
            send_bit(pl[i]);
        end
        gap(rnd);
        send_bit(p);
        chk("ready_low_in_commit", {31'd0, CFG_READY}, 32'd0);
        e.err    = exp_err;
        e.ts     = ets;
        e.dr     = edr;
        e.edge_n = cyc + 1;
        sbq.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1; CFG_VALID = 1'b0; CFG_ABORT = 1'b0; CFG_DIN = 1'b0;
        repeat (2) @(negedge IOCLK);
        chk("rst_tsmux", {28'd0, TSMUX_OUT}, 32'd0);
        chk("rst_dorreg", {30'd0, DORREG_OUT}, 32'd0);
        chk("rst_done", {31'd0, CFG_DONE}, 32'd0);
        chk("rst_err", {31'd0, CFG_ERR}, 32'd0);
        chk("rst_ready", {31'd0, CFG_READY}, 32'd1);
        RST = 1'b0;
        @(negedge IOCLK);

        // 101100 -> IO1 {10,1}, IO0 {10,0}; three ones so parity 1.
        send_frame(6'b101100, 1'b1, 1'b0, 4'b1010, 2'b10, 1'b0);
        // Same payload, wrong parity: error pulse, outputs hold.
        send_frame(6'b101100, 1'b0, 1'b1, 4'b1010, 2'b10, 1'b0);
        // Clear outputs, then garbage ahead of the real header with random stalls.
        // 0x5A is used because 0x52 followed by the leading 1 of A5 aliases the header.
        send_frame(6'b000000, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0);
        send_byte(8'h5A, 1'b1);
        send_frame(6'b101100, 1'b1, 1'b0, 4'b1010, 2'b10, 1'b1);

        // Abort on the 4th payload bit of 010101.
        send_byte(8'hA5, 1'b0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        CFG_VALID = 1'b1; CFG_DIN = 1'b1; CFG_ABORT = 1'b1;
        @(posedge IOCLK); @(negedge IOCLK);
        CFG_ABORT = 1'b0; CFG_VALID = 1'b0;
        repeat (3) @(negedge IOCLK);
        chk("abort_tsmux", {28'd0, TSMUX_OUT}, 32'hA);
        chk("abort_dorreg", {30'd0, DORREG_OUT}, 32'h2);
        chk("abort_ready", {31'd0, CFG_READY}, 32'd1);
        // 010101 -> IO1 {01,0}, IO0 {10,1}.
        send_frame(6'b010101, 1'b1, 1'b0, 4'b0110, 2'b01, 1'b0);

        // Back-to-back frames.
        send_frame(6'b111111, 1'b0, 1'b0, 4'b1111, 2'b11, 1'b0);
        send_frame(6'b000000, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0);

        // Reset in the middle of LOAD.
        send_frame(6'b111111, 1'b0, 1'b0, 4'b1111, 2'b11, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        RST = 1'b1;
        #1;
        chk("midrst_tsmux", {28'd0, TSMUX_OUT}, 32'd0);
        chk("midrst_dorreg", {30'd0, DORREG_OUT}, 32'd0);
        chk("midrst_ready", {31'd0, CFG_READY}, 32'd1);
        @(posedge IOCLK); @(negedge IOCLK);
        RST = 1'b0;
        @(negedge IOCLK);
        send_frame(6'b101100, 1'b1, 1'b0, 4'b1010, 2'b10, 1'b0);

        repeat (5) @(negedge IOCLK);
        chk("scoreboard_drained", sbq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
